// File: rtl/sys_cmd_ctrl_if.sv
// Bundle that connects sys_cmd_ctrl to the synced UART RX/TX paths, the RegFile and the ALU.
// master: the command controller, which drives RegFile/ALU requests, the TX byte and status.
// slave: the surroundings, which drive the RX byte, TX Busy, RegFile read data and the ALU result.
interface sys_cmd_ctrl_if #(
  parameter int ADDR_W    = 4,
  parameter int FUN_W     = 4,
  parameter int RES_BYTES = 2
);
  // UART side
  logic [7:0]             RX_P_DATA;
  logic                   RX_D_VLD;
  logic                   Busy;
  logic [7:0]             TX_P_DATA;
  logic                   TX_D_VLD;
  logic                   clk_div_en;
  // RegFile side
  logic [ADDR_W-1:0]      Address;
  logic                   WrEn;
  logic                   RdEn;
  logic [7:0]             WrData;
  logic [7:0]             RdData;
  logic                   RdData_Valid;
  // ALU side
  logic                   ALU_EN;
  logic [FUN_W-1:0]       ALU_FUN;
  logic                   CLK_EN;
  logic [8*RES_BYTES-1:0] ALU_OUT;
  logic                   OUT_Valid;
  // status
  logic                   rx_ovf;

  modport master (
    input  RX_P_DATA, RX_D_VLD, Busy, RdData, RdData_Valid, ALU_OUT, OUT_Valid,
    output TX_P_DATA, TX_D_VLD, clk_div_en, Address, WrEn, RdEn, WrData,
           ALU_EN, ALU_FUN, CLK_EN, rx_ovf
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, Busy, RdData, RdData_Valid, ALU_OUT, OUT_Valid,
    input  TX_P_DATA, TX_D_VLD, clk_div_en, Address, WrEn, RdEn, WrData,
           ALU_EN, ALU_FUN, CLK_EN, rx_ovf
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// Command controller: decodes RX byte frames, runs them on RegFile/ALU, queues response bytes for UART TX.
// Latency: last byte of a read frame to TX_D_VLD is 3 cycles with the RegFile answering 1 cycle after RdEn.
// Backpressure: responses wait in a FIFO_DEPTH-byte FIFO drained under Busy; a full FIFO stalls the
// command FSM in PUSH, and RX bytes that arrive while it is not accepting bytes are dropped (rx_ovf).
// Ports: CLK, RST (async, active-high); bus = sys_cmd_ctrl_if.master carrying all UART/RegFile/ALU signals.
module sys_cmd_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int FUN_W       = 4,
  parameter int RES_BYTES   = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic           CLK,
  input  logic           RST,
  sys_cmd_ctrl_if.master bus
);
  localparam int RES_W = 8 * RES_BYTES;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REM_W = $clog2(RES_BYTES + 1);
  localparam int TMO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_WDATA, WR, RD_REQ, RD_WAIT, GET_OPA, WR_OPA,
    GET_OPB, WR_OPB, GET_FUN, ALU_GO, ALU_WAIT, PUSH
  } cmd_state_e;

  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT_HI, T_WAIT_LO} tx_state_e;

  cmd_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [FUN_W-1:0]  fun_q, fun_d;
  logic              is_wr_q, is_wr_d;
  logic [RES_W-1:0]  res_q, res_d;   // bytes still to enqueue, LSB first
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              ovf_q, ovf_d;
  logic              div_en_q;

  tx_state_e         tx_q, tx_d;
  logic [5:0]        hi_cnt_q, hi_cnt_d;
  logic [7:0]        txd_q;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  used, free;
  logic              push, pop;
  logic [7:0]        head;

  logic              in_get, timeout, wr_en, rd_en, alu_en, clk_en;
  logic [ADDR_W-1:0] addr_out;

  assign used = wptr_q - rptr_q;
  // A pop in this cycle frees its slot for a push in the same cycle.
  assign free = CNT_W'(FIFO_DEPTH) - used + CNT_W'(pop);
  assign head = mem_q[rptr_q[PTR_W-1:0]];

  assign in_get = (state_q == GET_ADDR) || (state_q == GET_WDATA) || (state_q == GET_OPA) ||
                  (state_q == GET_OPB)  || (state_q == GET_FUN);
  assign timeout = in_get && !bus.RX_D_VLD && (TIMEOUT_CYC != 0) &&
                   (tmo_q == TMO_W'(TIMEOUT_CYC));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fun_d    = fun_q;
    is_wr_d  = is_wr_q;
    res_d    = res_q;
    rem_d    = rem_q;
    tmo_d    = '0;
    ovf_d    = ovf_q;
    push     = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    alu_en   = 1'b0;
    clk_en   = 1'b0;
    addr_out = addr_q;

    if (in_get && !bus.RX_D_VLD) tmo_d = tmo_q + TMO_W'(1);
    if (bus.RX_D_VLD && !in_get && state_q != IDLE) ovf_d = 1'b1;

    case (state_q)
      IDLE: if (bus.RX_D_VLD) begin
        case (bus.RX_P_DATA)
          8'hAA: begin is_wr_d = 1'b1; state_d = GET_ADDR; end
          8'hBB: begin is_wr_d = 1'b0; state_d = GET_ADDR; end
          8'hCC: state_d = GET_OPA;
          8'hDD: state_d = GET_FUN;
          default: begin
            res_d   = RES_W'(8'hEE);
            rem_d   = REM_W'(1);
            state_d = PUSH;
          end
        endcase
      end
      GET_ADDR: if (bus.RX_D_VLD) begin
        addr_d  = bus.RX_P_DATA[ADDR_W-1:0];
        state_d = is_wr_q ? GET_WDATA : RD_REQ;
      end
      GET_WDATA: if (bus.RX_D_VLD) begin
        wdata_d = bus.RX_P_DATA;
        state_d = WR;
      end
      WR: begin
        wr_en   = 1'b1;
        state_d = IDLE;
      end
      RD_REQ: begin
        rd_en   = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (bus.RdData_Valid) begin
        res_d   = RES_W'(bus.RdData);
        rem_d   = REM_W'(1);
        state_d = PUSH;
      end
      GET_OPA: if (bus.RX_D_VLD) begin
        wdata_d = bus.RX_P_DATA;
        state_d = WR_OPA;
      end
      WR_OPA: begin
        wr_en    = 1'b1;
        addr_out = '0;
        state_d  = GET_OPB;
      end
      GET_OPB: if (bus.RX_D_VLD) begin
        wdata_d = bus.RX_P_DATA;
        state_d = WR_OPB;
      end
      WR_OPB: begin
        wr_en    = 1'b1;
        addr_out = ADDR_W'(1);
        state_d  = GET_FUN;
      end
      GET_FUN: if (bus.RX_D_VLD) begin
        fun_d   = bus.RX_P_DATA[FUN_W-1:0];
        state_d = ALU_GO;
      end
      ALU_GO: begin
        alu_en  = 1'b1;
        clk_en  = 1'b1;
        state_d = ALU_WAIT;
      end
      ALU_WAIT: begin
        clk_en = 1'b1;
        if (bus.OUT_Valid) begin
          res_d   = bus.ALU_OUT;
          rem_d   = REM_W'(RES_BYTES);
          state_d = PUSH;
        end
      end
      PUSH: begin
        // Once the whole response fits, free space never drops below what is left,
        // so the bytes go out on consecutive cycles.
        if (32'(free) >= 32'(rem_q)) begin
          push  = 1'b1;
          res_d = res_q >> 8;
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      res_d   = RES_W'(8'hEF);
      rem_d   = REM_W'(1);
      state_d = PUSH;
    end
  end

  always_comb begin
    tx_d     = tx_q;
    hi_cnt_d = '0;
    pop      = 1'b0;
    case (tx_q)
      T_IDLE: if (used != '0 && !bus.Busy) begin
        pop  = 1'b1;
        tx_d = T_SEND;
      end
      // One cycle for the UART to register the strobe before Busy is sampled.
      T_SEND: tx_d = T_WAIT_HI;
      T_WAIT_HI: begin
        if (bus.Busy)                tx_d = T_WAIT_LO;
        else if (hi_cnt_q == 6'd63)  tx_d = T_IDLE;
        else                         hi_cnt_d = hi_cnt_q + 6'd1;
      end
      T_WAIT_LO: if (!bus.Busy) tx_d = T_IDLE;
      default: tx_d = T_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      fun_q    <= '0;
      is_wr_q  <= 1'b0;
      res_q    <= '0;
      rem_q    <= '0;
      tmo_q    <= '0;
      ovf_q    <= 1'b0;
      div_en_q <= 1'b0;
      tx_q     <= T_IDLE;
      hi_cnt_q <= '0;
      txd_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      fun_q    <= fun_d;
      is_wr_q  <= is_wr_d;
      res_q    <= res_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
      ovf_q    <= ovf_d;
      div_en_q <= 1'b1;
      tx_q     <= tx_d;
      hi_cnt_q <= hi_cnt_d;
      if (push) wptr_q <= wptr_q + CNT_W'(1);
      if (pop) begin
        rptr_q <= rptr_q + CNT_W'(1);
        txd_q  <= head;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q[PTR_W-1:0]] <= res_q[7:0];
  end

  assign bus.Address    = addr_out;
  assign bus.WrEn       = wr_en;
  assign bus.RdEn       = rd_en;
  assign bus.WrData     = wdata_q;
  assign bus.ALU_EN     = alu_en;
  assign bus.ALU_FUN    = fun_q;
  assign bus.CLK_EN     = clk_en;
  // The strobe is raised in the pop cycle itself; the byte is held afterwards.
  assign bus.TX_D_VLD   = pop;
  assign bus.TX_P_DATA  = pop ? head : txd_q;
  assign bus.clk_div_en = div_en_q;
  assign bus.rx_ovf     = ovf_q;
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl with small RegFile, ALU and UART TX models around it.
// Each task drives one scenario and compares against hand-computed values.
module tb_sys_cmd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sys_cmd_ctrl_if #(.ADDR_W(4), .FUN_W(4), .RES_BYTES(2)) bus ();

  sys_cmd_ctrl #(
    .ADDR_W(4), .FUN_W(4), .RES_BYTES(2), .FIFO_DEPTH(4), .TIMEOUT_CYC(1023)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // RegFile + ALU models (ALU: 0 ADD, 1 SUB, 2 MUL, else AND on regs 0/1)
  logic [7:0] regs [16];
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_f;
  logic [1:0] alu_dly;

  function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return {8'd0, a} + {8'd0, b};
      4'd1:    return {8'd0, a} - {8'd0, b};
      4'd2:    return {8'd0, a} * {8'd0, b};
      default: return {8'd0, a & b};
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'h40 + 8'(i);
      bus.RdData       <= '0;
      bus.RdData_Valid <= 1'b0;
      bus.ALU_OUT      <= '0;
      bus.OUT_Valid    <= 1'b0;
      alu_a <= '0; alu_b <= '0; alu_f <= '0; alu_dly <= '0;
    end else begin
      if (bus.WrEn) regs[bus.Address] <= bus.WrData;
      bus.RdData_Valid <= bus.RdEn;
      if (bus.RdEn) bus.RdData <= regs[bus.Address];
      bus.OUT_Valid <= 1'b0;
      if (bus.ALU_EN) begin
        alu_a <= regs[0]; alu_b <= regs[1]; alu_f <= bus.ALU_FUN; alu_dly <= 2'd2;
      end else if (alu_dly != 2'd0) begin
        alu_dly <= alu_dly - 2'd1;
        if (alu_dly == 2'd1) begin
          bus.OUT_Valid <= 1'b1;
          bus.ALU_OUT   <= alu_calc(alu_a, alu_b, alu_f);
        end
      end
    end
  end

  // Observer + UART TX busy model
  int         wr_n = 0, rd_n = 0, alu_n = 0, tx_n = 0, busy_cnt = 0;
  logic [3:0] wa_log [64];
  logic [7:0] wd_log [64];
  logic [7:0] tx_log [64];
  logic       clk_en_ov = 1'b0, clk_en_after = 1'b1, ov_d = 1'b0;
  logic       busy_hold;

  assign bus.Busy = busy_hold | (busy_cnt != 0);

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.WrEn) begin
        wa_log[wr_n % 64] <= bus.Address;
        wd_log[wr_n % 64] <= bus.WrData;
        wr_n <= wr_n + 1;
      end
      if (bus.RdEn) rd_n <= rd_n + 1;
      if (bus.ALU_EN) alu_n <= alu_n + 1;
      if (bus.OUT_Valid) clk_en_ov <= bus.CLK_EN;
      if (ov_d) clk_en_after <= bus.CLK_EN;
      ov_d <= bus.OUT_Valid;
      if (bus.TX_D_VLD) begin
        tx_log[tx_n % 64] <= bus.TX_P_DATA;
        tx_n     <= tx_n + 1;
        busy_cnt <= 8;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  function automatic logic [30:0] out_vec();
    return {bus.Address, bus.WrEn, bus.RdEn, bus.WrData, bus.ALU_EN, bus.ALU_FUN, bus.CLK_EN,
            bus.TX_P_DATA, bus.TX_D_VLD, bus.clk_div_en, bus.rx_ovf};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(negedge clk);
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx(input int target, input int budget, input string what);
    int n = 0;
    while (tx_n < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_n < target) begin
      errors++;
      $display("FAIL %s: only %0d TX bytes seen, required %0d", what, tx_n, target);
    end
  endtask

  task automatic test_reset();
    idle(2);
    checks++;
    if (out_vec() !== 31'd0) begin
      errors++; $display("FAIL reset_outputs: got %h, required 0", out_vec());
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.clk_div_en !== 1'b0) begin
      errors++; $display("FAIL clk_div_en_before_edge: got %b, required 0", bus.clk_div_en);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.clk_div_en !== 1'b1) begin
      errors++; $display("FAIL clk_div_en_after_edge: got %b, required 1", bus.clk_div_en);
    end
  endtask

  task automatic test_write_read();
    int w0 = wr_n, r0 = rd_n, t0 = tx_n, lat = 0;
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    idle(4);
    checks++;
    if (wr_n - w0 !== 1 || wa_log[w0 % 64] !== 4'h5 || wd_log[w0 % 64] !== 8'h3C) begin
      errors++;
      $display("FAIL write_frame: got %0d writes addr %h data %h, required 1 write addr 5 data 3c",
               wr_n - w0, wa_log[w0 % 64], wd_log[w0 % 64]);
    end
    send_byte(8'hBB); send_byte(8'h05);
    while (!bus.TX_D_VLD && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!bus.TX_D_VLD || lat > 4) begin
      errors++; $display("FAIL read_latency: got %0d cycles, required <= 4", lat);
    end
    checks++;
    if (bus.TX_P_DATA !== 8'h3C) begin
      errors++; $display("FAIL read_tx_data: got %h, required 3c", bus.TX_P_DATA);
    end
    wait_tx(t0 + 1, 50, "read_tx_count");
    idle(20);
    checks++;
    if (rd_n - r0 !== 1 || tx_n - t0 !== 1) begin
      errors++; $display("FAIL read_strobes: got %0d RdEn %0d TX, required 1 and 1", rd_n - r0, tx_n - t0);
    end
  endtask

  task automatic test_alu();
    int w0 = wr_n, a0 = alu_n, t0 = tx_n;
    send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
    wait_tx(t0 + 2, 100, "alu_tx_count");
    checks++;
    if (wr_n - w0 !== 2 || wa_log[w0 % 64] !== 4'h0 || wd_log[w0 % 64] !== 8'h05 ||
        wa_log[(w0 + 1) % 64] !== 4'h1 || wd_log[(w0 + 1) % 64] !== 8'h03) begin
      errors++;
      $display("FAIL alu_operand_writes: got %0d writes (%h:%h %h:%h), required 2 (0:05 1:03)", wr_n - w0,
               wa_log[w0 % 64], wd_log[w0 % 64], wa_log[(w0 + 1) % 64], wd_log[(w0 + 1) % 64]);
    end
    checks++;
    if (alu_n - a0 !== 1) begin
      errors++; $display("FAIL alu_en_count: got %0d, required 1", alu_n - a0);
    end
    checks++;
    if (tx_log[t0 % 64] !== 8'h08 || tx_log[(t0 + 1) % 64] !== 8'h00) begin
      errors++; $display("FAIL alu_add_bytes: got %h %h, required 08 00", tx_log[t0 % 64], tx_log[(t0 + 1) % 64]);
    end
    checks++;
    if (clk_en_ov !== 1'b1 || clk_en_after !== 1'b0) begin
      errors++; $display("FAIL clk_en_window: got %b/%b, required 1/0", clk_en_ov, clk_en_after);
    end
    idle(20);
    t0 = tx_n;
    send_byte(8'hDD); send_byte(8'h02);
    wait_tx(t0 + 2, 100, "dd_tx_count");
    checks++;
    if (tx_log[t0 % 64] !== 8'h0F || tx_log[(t0 + 1) % 64] !== 8'h00) begin
      errors++; $display("FAIL dd_mul_bytes: got %h %h, required 0f 00", tx_log[t0 % 64], tx_log[(t0 + 1) % 64]);
    end
    idle(20);
  endtask

  task automatic test_bad_opcode();
    int w0 = wr_n, r0 = rd_n, a0 = alu_n, t0 = tx_n;
    send_byte(8'h12);
    wait_tx(t0 + 1, 50, "bad_op_tx_count");
    idle(30);
    checks++;
    if (tx_n - t0 !== 1 || tx_log[t0 % 64] !== 8'hEE) begin
      errors++; $display("FAIL bad_op_response: got %0d bytes first %h, required 1 byte ee", tx_n - t0, tx_log[t0 % 64]);
    end
    checks++;
    if (wr_n != w0 || rd_n != r0 || alu_n != a0) begin
      errors++; $display("FAIL bad_op_strobes: got %0d/%0d/%0d, required 0/0/0", wr_n - w0, rd_n - r0, alu_n - a0);
    end
  endtask

  task automatic test_timeout();
    int w0 = wr_n, t0 = tx_n;
    send_byte(8'hAA); send_byte(8'h02);
    wait_tx(t0 + 1, 1500, "timeout_tx_count");
    idle(20);
    checks++;
    if (tx_log[t0 % 64] !== 8'hEF || wr_n != w0) begin
      errors++; $display("FAIL timeout_response: got %h with %0d writes, required ef with 0", tx_log[t0 % 64], wr_n - w0);
    end
    t0 = tx_n;
    send_byte(8'hBB); send_byte(8'h02);
    wait_tx(t0 + 1, 50, "post_timeout_read");
    idle(20);
    checks++;
    if (tx_log[t0 % 64] !== 8'h42) begin
      errors++; $display("FAIL post_timeout_read_data: got %h, required 42", tx_log[t0 % 64]);
    end
    // A gap just under the limit must not abort the frame.
    w0 = wr_n; t0 = tx_n;
    send_byte(8'hAA); send_byte(8'h03);
    idle(1000);
    send_byte(8'h77);
    idle(5);
    checks++;
    if (wr_n - w0 !== 1 || wa_log[w0 % 64] !== 4'h3 || wd_log[w0 % 64] !== 8'h77 || tx_n != t0) begin
      errors++; $display("FAIL slow_frame_write: got %0d writes addr %h data %h, %0d TX, required 1 write 3:77, 0 TX",
                         wr_n - w0, wa_log[w0 % 64], wd_log[w0 % 64], tx_n - t0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [6];
    int t0;
    exp[0] = 8'h08; exp[1] = 8'h00; exp[2] = 8'h0F; exp[3] = 8'h00; exp[4] = 8'h02; exp[5] = 8'h00;
    busy_hold = 1'b1;
    idle(20);
    t0 = tx_n;
    send_byte(8'hDD); send_byte(8'h00); idle(10);
    send_byte(8'hDD); send_byte(8'h02); idle(10);
    checks++;
    if (bus.rx_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_before_stall: got %b, required 0", bus.rx_ovf);
    end
    send_byte(8'hDD); send_byte(8'h01); idle(10);
    send_byte(8'h55); idle(3);
    checks++;
    if (bus.rx_ovf !== 1'b1 || tx_n != t0) begin
      errors++; $display("FAIL stall_ovf: got ovf %b with %0d TX, required ovf 1 with 0 TX", bus.rx_ovf, tx_n - t0);
    end
    busy_hold = 1'b0;
    wait_tx(t0 + 6, 400, "drain_tx_count");
    idle(60);
    checks++;
    if (tx_n - t0 !== 6) begin
      errors++; $display("FAIL drain_total: got %0d bytes, required 6", tx_n - t0);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (tx_log[(t0 + i) % 64] !== exp[i]) begin
        errors++; $display("FAIL drain_byte_%0d: got %h, required %h", i, tx_log[(t0 + i) % 64], exp[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int w0, a0 = alu_n;
    send_byte(8'hCC);
    rst = 1'b1;
    #1;
    checks++;
    if (out_vec() !== 31'd0) begin
      errors++; $display("FAIL midframe_reset_outputs: got %h, required 0", out_vec());
    end
    idle(3);
    rst = 1'b0;
    w0 = wr_n;
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h99);
    idle(5);
    checks++;
    if (wr_n - w0 !== 1 || wa_log[w0 % 64] !== 4'h7 || wd_log[w0 % 64] !== 8'h99 || alu_n != a0) begin
      errors++; $display("FAIL post_reset_write: got %0d writes addr %h data %h, %0d ALU_EN, required 1 write 7:99, 0 ALU_EN",
                         wr_n - w0, wa_log[w0 % 64], wd_log[w0 % 64], alu_n - a0);
    end
  endtask

  initial begin
    bus.RX_P_DATA = 8'h00;
    bus.RX_D_VLD  = 1'b0;
    busy_hold     = 1'b0;
    test_reset();
    test_write_read();
    test_alu();
    test_bad_opcode();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
